aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_key_expander_if.sv | 37 +++
 rtl/aes_sbox_word.sv | 29 ++
 rtl/aes_key_expander.sv | 165 ++++++++++++++++
 tb/tb_aes_key_expander.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: controller states, round constants
// and the key-length-derived sizes (NK, NR, NW).
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } kx_state_e;

    // Rcon[1..10] stored at index 0..9
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    function automatic int aes_nk(input int key_len);
        return key_len / 32;
    endfunction

    function automatic int aes_nr(input int key_len);
        return key_len / 32 + 6;
    endfunction

    function automatic int aes_nw(input int key_len);
        return 4 * (aes_nr(key_len) + 1);
    endfunction

    // Round constant for schedule step n (1-based); 0 outside the table
    function automatic logic [7:0] aes_rcon(input logic [3:0] n);
        if (n >= 4'd1 && n <= 4'd10) return RCON[n - 4'd1];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Control/read bus of the AES key expander. The zeroize line exists only
// when AES_KEYEXP_ZEROIZE_EN is defined.
interface aes_key_expander_if #(
    parameter int KEY_LEN = 128
);
    logic               start;
    logic [KEY_LEN-1:0] key;
    logic               busy;
    logic               done;
    logic               rk_req;
    logic [3:0]         rk_idx;
    logic               dec;
    logic               rk_valid;
    logic [127:0]       rk_data;
    logic               rk_err;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic               zeroize;

    modport master (
        output start, key, rk_req, rk_idx, dec, zeroize,
        input  busy, done, rk_valid, rk_data, rk_err
    );
    modport slave (
        input  start, key, rk_req, rk_idx, dec, zeroize,
        output busy, done, rk_valid, rk_data, rk_err
    );
`else
    modport master (
        output start, key, rk_req, rk_idx, dec,
        input  busy, done, rk_valid, rk_data, rk_err
    );
    modport slave (
        input  start, key, rk_req, rk_idx, dec,
        output busy, done, rk_valid, rk_data, rk_err
    );
`endif
endinterface

// File: rtl/aes_sbox_word.sv
// Four parallel AES forward S-boxes applied bytewise to a 32-bit word.
module aes_sbox_word (
    input  logic [31:0] in_i,
    output logic [31:0] out_o
);
    // Entry x sits at bits [8*(255-x) +: 8], i.e. index {~x, 3'b000}
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign out_o[8*b +: 8] = SBOX[{~in_i[8*b +: 8], 3'b000} +: 8];
    end
endmodule

// File: rtl/aes_key_expander.sv
// AES key expander: loads a 128/192/256-bit key, computes the full
// schedule one word per cycle into a flop array, then serves round keys
// in encryption or decryption order. Optional AES_KEYEXP_ZEROIZE_EN adds
// a zeroize input that wipes the schedule and output register.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128
) (
    input  logic              clk,
    input  logic              rst,
    aes_key_expander_if.slave bus
);
    localparam int NK = aes_nk(KEY_LEN);
    localparam int NR = aes_nr(KEY_LEN);
    localparam int NW = aes_nw(KEY_LEN);

    kx_state_e    state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic [31:0]  w_q [NW];
    logic [127:0] rk_data_q, rk_data_d;
    logic         done_q, done_d;
    logic         rk_valid_q, rk_valid_d;
    logic         rk_err_q, rk_err_d;
    logic         load, exp_we, clr;

    logic [31:0]  w_prev, w_old, sbox_in, sbox_out, temp, w_new;
    logic [7:0]   rc;
    logic [3:0]   row;
    logic [5:0]   base;
    int           i_mod;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign clr = bus.zeroize;
`else
    assign clr = 1'b0;
`endif

    aes_sbox_word u_sbox (
        .in_i  (sbox_in),
        .out_o (sbox_out)
    );

    // Next schedule word from w[i-1] and w[i-NK]
    always_comb begin
        w_prev  = w_q[i_q - 6'd1];
        w_old   = w_q[i_q - 6'(NK)];
        i_mod   = int'(i_q) % NK;
        rc      = aes_rcon(4'(int'(i_q) / NK));
        sbox_in = (i_mod == 0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (i_mod == 0)                temp = sbox_out ^ {rc, 24'h0};
        else if (NK == 8 && i_mod == 4) temp = sbox_out;
        else                           temp = w_prev;
        w_new = w_old ^ temp;
    end

    // Round-key row selection; decryption order walks the rounds backwards
    always_comb begin
        row  = bus.dec ? 4'(NR) - bus.rk_idx : bus.rk_idx;
        base = {row, 2'b00};
    end

    // Controller next state, schedule write enables and read responses
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        load       = 1'b0;
        exp_we     = 1'b0;
        done_d     = 1'b0;
        rk_valid_d = 1'b0;
        rk_err_d   = 1'b0;
        rk_data_d  = rk_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    i_d     = 6'(NK);
                end
                if (bus.rk_req) rk_err_d = 1'b1;
            end
            EXPAND: begin
                exp_we = 1'b1;
                if (i_q == 6'(NW - 1)) begin
                    state_d = READY;
                    done_d  = 1'b1;
                end else begin
                    i_d = i_q + 6'd1;
                end
                if (bus.rk_req) rk_err_d = 1'b1;
            end
            READY: begin
                // A restart wins; a read in the same cycle is silently dropped
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    i_d     = 6'(NK);
                end else if (bus.rk_req) begin
                    if (bus.rk_idx <= 4'(NR)) begin
                        rk_valid_d = 1'b1;
                        rk_data_d  = {w_q[base], w_q[base | 6'd1],
                                      w_q[base | 6'd2], w_q[base | 6'd3]};
                    end else begin
                        rk_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d    = IDLE;
            i_d        = '0;
            load       = 1'b0;
            exp_we     = 1'b0;
            done_d     = 1'b0;
            rk_valid_d = 1'b0;
            rk_err_d   = 1'b0;
            rk_data_d  = '0;
        end
        if (!rst) begin
            load   = 1'b0;
            exp_we = 1'b0;
        end
    end

    // Controller and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            rk_err_q   <= rk_err_d;
            rk_data_q  <= rk_data_d;
        end
    end

    // Schedule storage: key load, one expanded word per cycle, optional wipe
    always_ff @(posedge clk) begin
`ifdef AES_KEYEXP_ZEROIZE_EN
        if (!rst || clr) begin
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else
`endif
        if (load) begin
            for (int k = 0; k < NK; k++) w_q[k] <= bus.key[KEY_LEN-1-32*k -: 32];
        end else if (exp_we) begin
            w_q[i_q] <= w_new;
        end
    end

    assign bus.busy     = (state_q == EXPAND);
    assign bus.done     = done_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_data  = rk_data_q;
    assign bus.rk_err   = rk_err_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander at KEY_LEN 128/192/256 using
// published AES key-schedule vectors and a round-key scoreboard.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [127:0] sb [$];

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R0   = K128;
    localparam logic [127:0] R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R8   = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R1_192 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;

    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1_256 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R3_256 = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    localparam logic [3:0]   RIDX [8] = '{4'd10, 4'd0, 4'd0, 4'd1, 4'd8, 4'd9, 4'd2, 4'd1};
    localparam logic         RDEC [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [127:0] REXP [8] = '{R10, R10, R0, R1, R8, R9, R8, R9};

    localparam logic [3:0]   I192 [3] = '{4'd12, 4'd1, 4'd0};
    localparam logic         D192 [3] = '{1'b0, 1'b0, 1'b1};
    localparam logic [127:0] E192 [3] = '{R12_192, R1_192, R12_192};
    localparam logic [3:0]   I256 [3] = '{4'd14, 4'd1, 4'd11};
    localparam logic         D256 [3] = '{1'b0, 1'b0, 1'b1};
    localparam logic [127:0] E256 [3] = '{R14_256, R1_256, R3_256};

    aes_key_expander_if #(.KEY_LEN(128)) bus128 ();
    aes_key_expander_if #(.KEY_LEN(192)) bus192 ();
    aes_key_expander_if #(.KEY_LEN(256)) bus256 ();

    aes_key_expander #(.KEY_LEN(128)) dut128 (.clk(clk), .rst(rst), .bus(bus128));
    aes_key_expander #(.KEY_LEN(192)) dut192 (.clk(clk), .rst(rst), .bus(bus192));
    aes_key_expander #(.KEY_LEN(256)) dut256 (.clk(clk), .rst(rst), .bus(bus256));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus128.start = 0; bus128.key = '0; bus128.rk_req = 0; bus128.rk_idx = '0; bus128.dec = 0;
        bus192.start = 0; bus192.key = '0; bus192.rk_req = 0; bus192.rk_idx = '0; bus192.dec = 0;
        bus256.start = 0; bus256.key = '0; bus256.rk_req = 0; bus256.rk_idx = '0; bus256.dec = 0;
`ifdef AES_KEYEXP_ZEROIZE_EN
        bus128.zeroize = 0; bus192.zeroize = 0; bus256.zeroize = 0;
`endif
    endtask

    // Starts the 128-bit expander and waits for done; cyc = -1 on timeout
    task automatic run128(output int cyc);
        bus128.key = K128; bus128.start = 1; cyc = -1;
        for (int t = 1; t <= 80; t++) begin
            tick; bus128.start = 0;
            if (bus128.done) begin cyc = t; break; end
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (3) tick;
        n_cmp++;
        if ({bus128.busy, bus128.done, bus128.rk_valid, bus128.rk_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags128: got %b want 0000",
                {bus128.busy, bus128.done, bus128.rk_valid, bus128.rk_err});
        end
        n_cmp++;
        if (bus128.rk_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_data128: got %h want 0", bus128.rk_data);
        end
        n_cmp++;
        if ({bus192.busy, bus192.done, bus256.busy, bus256.done, bus192.rk_err, bus256.rk_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags192_256: got %b want 000000",
                {bus192.busy, bus192.done, bus256.busy, bus256.done, bus192.rk_err, bus256.rk_err});
        end
        rst = 1;
        bus128.rk_req = 1; bus128.rk_idx = 4'd0;
        tick; bus128.rk_req = 0;
        n_cmp++;
        if ({bus128.rk_err, bus128.rk_valid} !== 2'b10) begin
            n_fail++; $display("FAIL idle_read: got err/valid %b want 10", {bus128.rk_err, bus128.rk_valid});
        end
        tick;
        n_cmp++;
        if (bus128.rk_err !== 1'b0) begin
            n_fail++; $display("FAIL idle_err_pulse: got %b want 0", bus128.rk_err);
        end
    endtask

    task automatic test_expand128;
        int cyc; logic busy_ok;
        bus128.key = K128; bus128.start = 1; cyc = -1; busy_ok = 1;
        for (int t = 1; t <= 80; t++) begin
            tick; bus128.start = 0;
            if (bus128.done) begin cyc = t; break; end
            if (bus128.busy !== 1'b1) busy_ok = 0;
        end
        n_cmp++;
        if (cyc != 41) begin n_fail++; $display("FAIL latency128: got %0d want 41", cyc); end
        n_cmp++;
        if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL busy_during_expand: got 0 want 1"); end
        n_cmp++;
        if (bus128.busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", bus128.busy); end
        tick;
        n_cmp++;
        if (bus128.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", bus128.done); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] exp;
        bus128.rk_req = 1; bus128.rk_idx = RIDX[0]; bus128.dec = RDEC[0]; sb.push_back(REXP[0]);
        for (int n = 0; n < 8; n++) begin
            tick;
            if (n < 7) begin
                bus128.rk_idx = RIDX[n+1]; bus128.dec = RDEC[n+1]; sb.push_back(REXP[n+1]);
            end else begin
                bus128.rk_req = 0;
            end
            exp = sb.pop_front();
            n_cmp++;
            if (bus128.rk_valid !== 1'b1 || bus128.rk_data !== exp) begin
                n_fail++; $display("FAIL rd128_%0d: valid=%b data=%h want valid=1 data=%h",
                    n, bus128.rk_valid, bus128.rk_data, exp);
            end
        end
    endtask

    task automatic test_illegal;
        bus128.rk_req = 1; bus128.rk_idx = 4'd11; bus128.dec = 0;
        tick; bus128.rk_req = 0;
        n_cmp++;
        if ({bus128.rk_err, bus128.rk_valid} !== 2'b10) begin
            n_fail++; $display("FAIL idx11_err: got err/valid %b want 10", {bus128.rk_err, bus128.rk_valid});
        end
        n_cmp++;
        if (bus128.rk_data !== R9) begin
            n_fail++; $display("FAIL idx11_data_hold: got %h want %h", bus128.rk_data, R9);
        end
        tick;
        n_cmp++;
        if (bus128.rk_err !== 1'b0) begin n_fail++; $display("FAIL idx11_err_pulse: got %b want 0", bus128.rk_err); end
    endtask

    task automatic test_start_ignored;
        int cyc; logic [127:0] exp;
        bus128.key = K128; bus128.start = 1; cyc = -1;
        for (int t = 1; t <= 80; t++) begin
            tick; bus128.start = 0; bus128.rk_req = 0;
            if (t == 2) begin
                n_cmp++;
                if ({bus128.rk_err, bus128.rk_valid} !== 2'b10) begin
                    n_fail++; $display("FAIL expand_read: got err/valid %b want 10", {bus128.rk_err, bus128.rk_valid});
                end
            end
            if (bus128.done) begin cyc = t; break; end
            if (t == 1) begin bus128.rk_req = 1; bus128.rk_idx = 4'd0; bus128.dec = 0; end
            if (t == 10) begin bus128.start = 1; bus128.key = '0; end
        end
        n_cmp++;
        if (cyc != 41) begin n_fail++; $display("FAIL restart_latency: got %0d want 41", cyc); end
        bus128.rk_req = 1; bus128.rk_idx = 4'd10; bus128.dec = 0; sb.push_back(R10);
        tick; bus128.rk_req = 0;
        exp = sb.pop_front();
        n_cmp++;
        if (bus128.rk_valid !== 1'b1 || bus128.rk_data !== exp) begin
            n_fail++; $display("FAIL start_ignored_r10: valid=%b data=%h want valid=1 data=%h",
                bus128.rk_valid, bus128.rk_data, exp);
        end
    endtask

    task automatic test_start_priority;
        int cyc;
        bus128.key = K128; bus128.start = 1; bus128.rk_req = 1; bus128.rk_idx = 4'd0;
        tick; bus128.start = 0; bus128.rk_req = 0;
        n_cmp++;
        if ({bus128.rk_valid, bus128.rk_err, bus128.busy} !== 3'b001) begin
            n_fail++; $display("FAIL start_priority: got valid/err/busy %b want 001",
                {bus128.rk_valid, bus128.rk_err, bus128.busy});
        end
        cyc = -1;
        for (int t = 2; t <= 80; t++) begin
            tick;
            if (bus128.done) begin cyc = t; break; end
        end
        n_cmp++;
        if (cyc != 41) begin n_fail++; $display("FAIL priority_latency: got %0d want 41", cyc); end
    endtask

    task automatic test_reset_abort;
        logic seen_done;
        bus128.key = K128; bus128.start = 1;
        for (int t = 1; t <= 20; t++) begin tick; bus128.start = 0; end
        rst = 0;
        tick;
        n_cmp++;
        if ({bus128.busy, bus128.done} !== 2'b00) begin
            n_fail++; $display("FAIL abort_busy_done: got %b want 00", {bus128.busy, bus128.done});
        end
        rst = 1; seen_done = 0;
        for (int t = 0; t < 50; t++) begin tick; if (bus128.done) seen_done = 1; end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 want 0"); end
        bus128.rk_req = 1; bus128.rk_idx = 4'd0;
        tick; bus128.rk_req = 0;
        n_cmp++;
        if ({bus128.rk_err, bus128.rk_valid, bus128.busy} !== 3'b100) begin
            n_fail++; $display("FAIL abort_idle_read: got err/valid/busy %b want 100",
                {bus128.rk_err, bus128.rk_valid, bus128.busy});
        end
    endtask

    task automatic test_key192_256;
        int c192, c256; logic [127:0] e1, e2;
        bus192.key = K192; bus192.start = 1;
        bus256.key = K256; bus256.start = 1;
        c192 = -1; c256 = -1;
        for (int t = 1; t <= 80; t++) begin
            tick; bus192.start = 0; bus256.start = 0;
            if (bus192.done && c192 < 0) c192 = t;
            if (bus256.done && c256 < 0) c256 = t;
            if (c192 > 0 && c256 > 0) break;
        end
        n_cmp++;
        if (c192 != 47) begin n_fail++; $display("FAIL latency192: got %0d want 47", c192); end
        n_cmp++;
        if (c256 != 53) begin n_fail++; $display("FAIL latency256: got %0d want 53", c256); end
        for (int n = 0; n < 3; n++) begin
            bus192.rk_req = 1; bus192.rk_idx = I192[n]; bus192.dec = D192[n]; sb.push_back(E192[n]);
            bus256.rk_req = 1; bus256.rk_idx = I256[n]; bus256.dec = D256[n]; sb.push_back(E256[n]);
            tick; bus192.rk_req = 0; bus256.rk_req = 0;
            e1 = sb.pop_front(); e2 = sb.pop_front();
            n_cmp++;
            if (bus192.rk_valid !== 1'b1 || bus192.rk_data !== e1) begin
                n_fail++; $display("FAIL rd192_%0d: valid=%b data=%h want valid=1 data=%h",
                    n, bus192.rk_valid, bus192.rk_data, e1);
            end
            n_cmp++;
            if (bus256.rk_valid !== 1'b1 || bus256.rk_data !== e2) begin
                n_fail++; $display("FAIL rd256_%0d: valid=%b data=%h want valid=1 data=%h",
                    n, bus256.rk_valid, bus256.rk_data, e2);
            end
        end
    endtask

`ifdef AES_KEYEXP_ZEROIZE_EN
    task automatic test_zeroize;
        int cyc;
        run128(cyc);
        n_cmp++;
        if (cyc != 41) begin n_fail++; $display("FAIL zeroize_prep_latency: got %0d want 41", cyc); end
        bus128.rk_req = 1; bus128.rk_idx = 4'd10; bus128.dec = 0;
        tick;
        bus128.zeroize = 1; bus128.start = 1;
        tick; bus128.zeroize = 0; bus128.start = 0; bus128.rk_req = 0;
        n_cmp++;
        if ({bus128.busy, bus128.rk_valid, bus128.rk_err} !== 3'b000 || bus128.rk_data !== 128'h0) begin
            n_fail++; $display("FAIL zeroize_state: busy/valid/err=%b data=%h want 000 data=0",
                {bus128.busy, bus128.rk_valid, bus128.rk_err}, bus128.rk_data);
        end
        bus128.rk_req = 1; bus128.rk_idx = 4'd0;
        tick; bus128.rk_req = 0;
        n_cmp++;
        if ({bus128.rk_err, bus128.rk_valid} !== 2'b10 || bus128.rk_data !== 128'h0) begin
            n_fail++; $display("FAIL zeroize_read: err/valid=%b data=%h want 10 data=0",
                {bus128.rk_err, bus128.rk_valid}, bus128.rk_data);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_expand128();
        test_back_to_back();
        test_illegal();
        test_start_ignored();
        test_start_priority();
        test_reset_abort();
        test_key192_256();
`ifdef AES_KEYEXP_ZEROIZE_EN
        test_zeroize();
`endif
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
